decode_ex_ctrl: RTL and testbench

Instruction control decoder plus registered ID/EX control pipeline stage for the RV32I core. It decodes the instruction word in Decode into the `ALUControl` and datapath-select signals the execute-stage ALU and muxes consume, and registers them into Execute. The register honours stall and flush from the hazard unit. Only `ImmSrcD` is combinational, for the decode-stage immediate extender.

---
 rtl/decode_ex_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_decode_ex_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ex_ctrl.sv
// RV32I control decoder with the registered ID/EX control stage.
// ImmSrcD is the only combinational output; everything else is held in e_reg.
module decode_ex_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] InstrD,
  input  logic                  ValidD,
  input  logic                  StallE,
  input  logic                  FlushE,
  output logic [2:0]            ImmSrcD,
  output logic [3:0]            ALUControlE,
  output logic                  ALUSrcE,
  output logic [1:0]            SrcASelE,
  output logic [1:0]            ResultSrcE,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  BranchE,
  output logic                  JumpE,
  output logic                  JalrE,
  output logic [2:0]            Funct3E,
  output logic [4:0]            Rs1E,
  output logic [4:0]            Rs2E,
  output logic [4:0]            RdE,
  output logic                  IllegalE,
  output logic                  ValidE
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef struct packed {
    logic [3:0] alu_control;
    logic       alu_src;
    logic [1:0] src_a_sel;
    logic [1:0] result_src;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       illegal;
    logic       valid;
  } ex_ctrl_t;

  // Shared funct3 -> ALU op map of the R-type and I-ALU groups; alt selects sub/sra.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  logic [2:0] imm_src;
  ex_ctrl_t   dec;
  ex_ctrl_t   e_next;
  ex_ctrl_t   e_reg;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign funct7 = InstrD[31:25];

  always_comb begin
    dec     = '0;
    imm_src = IMM_I;
    legal   = 1'b1;
    case (opcode)
      OP_R: begin
        dec.reg_write   = 1'b1;
        dec.alu_control = alu_op(funct3, funct7 == F7_ALT);
        legal = (funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OP_I: begin
        dec.reg_write   = 1'b1;
        dec.alu_src     = 1'b1;
        dec.alu_control = alu_op(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
        case (funct3)
          3'b001:  legal = (funct7 == F7_BASE);
          3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          default: legal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b01;
        dec.reg_write  = 1'b1;
      end
      OP_STORE: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        imm_src       = IMM_S;
      end
      OP_BRANCH: begin
        dec.branch = 1'b1;
        imm_src    = IMM_B;
        case (funct3[2:1])
          2'b00:   dec.alu_control = ALU_SUB;
          2'b10:   dec.alu_control = ALU_SLT;
          2'b11:   dec.alu_control = ALU_SLTU;
          default: legal = 1'b0;
        endcase
      end
      OP_LUI: begin
        dec.src_a_sel = 2'b10;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        imm_src       = IMM_U;
      end
      OP_AUIPC: begin
        dec.src_a_sel = 2'b01;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        imm_src       = IMM_U;
      end
      OP_JAL: begin
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
        dec.reg_write  = 1'b1;
        imm_src        = IMM_J;
      end
      OP_JALR: begin
        dec.alu_src    = 1'b1;
        dec.jump       = 1'b1;
        dec.jalr       = 1'b1;
        dec.result_src = 2'b10;
        dec.reg_write  = 1'b1;
        legal          = (funct3 == 3'b000);
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal words keep only their register fields; an invalid slot is a plain bubble.
  always_comb begin
    e_next = '0;
    if (ValidD) begin
      if (legal) begin
        e_next        = dec;
        e_next.funct3 = funct3;
      end
      e_next.rs1     = InstrD[19:15];
      e_next.rs2     = InstrD[24:20];
      e_next.rd      = InstrD[11:7];
      e_next.illegal = ~legal;
      e_next.valid   = 1'b1;
    end
  end

  assign ImmSrcD = legal ? imm_src : IMM_I;

  always_ff @(posedge clk) begin
    if (rst) begin
      e_reg <= '0;
    end else if (FlushE) begin
      e_reg <= '0;
    end else if (!StallE) begin
      e_reg <= e_next;
    end
  end

  assign ALUControlE = e_reg.alu_control;
  assign ALUSrcE     = e_reg.alu_src;
  assign SrcASelE    = e_reg.src_a_sel;
  assign ResultSrcE  = e_reg.result_src;
  assign RegWriteE   = e_reg.reg_write;
  assign MemWriteE   = e_reg.mem_write;
  assign BranchE     = e_reg.branch;
  assign JumpE       = e_reg.jump;
  assign JalrE       = e_reg.jalr;
  assign Funct3E     = e_reg.funct3;
  assign Rs1E        = e_reg.rs1;
  assign Rs2E        = e_reg.rs2;
  assign RdE         = e_reg.rd;
  assign IllegalE    = e_reg.illegal;
  assign ValidE      = e_reg.valid;

endmodule

// File: tb/tb_decode_ex_ctrl.sv
// Bench for decode_ex_ctrl: hand-written vector table, stall/flush/reset
// sequences, then random traffic against an instruction-level reference model.
module tb_decode_ex_ctrl;

  typedef struct packed {
    logic [3:0] alu;
    logic       alu_src;
    logic [1:0] src_a;
    logic [1:0] res_src;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [2:0] f3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       illegal;
    logic       valid;
  } ctrl_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        valid;
    logic [2:0]  imm;
    ctrl_t       exp;
  } vec_t;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4;
  localparam logic [3:0] SLL = 4'd5, SRA = 4'd6, SRL = 4'd7, SLT = 4'd8, SLTU = 4'd9;

  logic        clk = 1'b0;
  logic        rst, ValidD, StallE, FlushE;
  logic [31:0] InstrD;
  logic [2:0]  ImmSrcD;
  logic [3:0]  ALUControlE;
  logic        ALUSrcE;
  logic [1:0]  SrcASelE, ResultSrcE;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, JalrE;
  logic [2:0]  Funct3E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        IllegalE, ValidE;

  int    n_cmp = 0;
  int    n_bad = 0;
  ctrl_t exp_e;
  ctrl_t got;

  decode_ex_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD),
    .StallE(StallE), .FlushE(FlushE), .ImmSrcD(ImmSrcD),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .SrcASelE(SrcASelE),
    .ResultSrcE(ResultSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .Funct3E(Funct3E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .IllegalE(IllegalE), .ValidE(ValidE)
  );

  always #5 clk = ~clk;

  assign got = {ALUControlE, ALUSrcE, SrcASelE, ResultSrcE, RegWriteE, MemWriteE,
                BranchE, JumpE, JalrE, Funct3E, Rs1E, Rs2E, RdE, IllegalE, ValidE};

  function automatic ctrl_t mk(logic [3:0] alu, logic asrc, logic [1:0] sa, logic [1:0] rs,
                               logic rw, logic mw, logic br, logic j, logic jr, logic [2:0] f3,
                               logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
                               logic ill, logic v);
    return {alu, asrc, sa, rs, rw, mw, br, j, jr, f3, r1, r2, rd, ill, v};
  endfunction

  // Reference model: instruction word -> expected Execute controls and ImmSrc.
  task automatic model(input logic [31:0] ins, input logic v, output ctrl_t e, output logic [2:0] imm);
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic       ok;
    logic [3:0] alu_map [8];
    logic [3:0] br_map [8];
    ctrl_t      c;
    alu_map = '{ADD, SLL, SLT, SLTU, XOR_, SRL, OR_, AND_};
    br_map  = '{SUB, SUB, ADD, ADD, SLT, SLT, SLTU, SLTU};
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    c = '0; imm = 3'd0; ok = 1'b1;
    case (op)
      7'h33: begin
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        c.alu = (f7 == 7'h20 && f3 == 3'd0) ? SUB : (f7 == 7'h20 && f3 == 3'd5) ? SRA : alu_map[f3];
        c.reg_write = 1'b1;
      end
      7'h13: begin
        ok = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        c.alu = (f3 == 3'd5 && f7 == 7'h20) ? SRA : alu_map[f3];
        c.alu_src = 1'b1; c.reg_write = 1'b1;
      end
      7'h03: begin c.alu_src = 1'b1; c.res_src = 2'b01; c.reg_write = 1'b1; end
      7'h23: begin c.alu_src = 1'b1; c.mem_write = 1'b1; imm = 3'd1; end
      7'h63: begin ok = (f3 != 3'd2) && (f3 != 3'd3); c.alu = br_map[f3]; c.branch = 1'b1; imm = 3'd2; end
      7'h37: begin c.src_a = 2'b10; c.alu_src = 1'b1; c.reg_write = 1'b1; imm = 3'd3; end
      7'h17: begin c.src_a = 2'b01; c.alu_src = 1'b1; c.reg_write = 1'b1; imm = 3'd3; end
      7'h6F: begin c.jump = 1'b1; c.res_src = 2'b10; c.reg_write = 1'b1; imm = 3'd4; end
      7'h67: begin
        ok = (f3 == 3'd0);
        c.alu_src = 1'b1; c.jump = 1'b1; c.jalr = 1'b1; c.res_src = 2'b10; c.reg_write = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      c = '0; imm = 3'd0;
    end else begin
      c.f3 = f3;
    end
    c.rs1 = ins[19:15]; c.rs2 = ins[24:20]; c.rd = ins[11:7];
    c.illegal = ~ok; c.valid = 1'b1;
    if (!v) c = '0;
    e = c;
  endtask

  task automatic check_e(input string name, input ctrl_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: E outputs got %h want %h", name, got, want);
    end
  endtask

  task automatic check_imm(input string name, input logic [2:0] want);
    n_cmp++;
    if (ImmSrcD !== want) begin
      n_bad++;
      $display("FAIL %s: ImmSrcD got %b want %b", name, ImmSrcD, want);
    end
  endtask

  task automatic check_bit(input string name, input logic actual, input logic want);
    n_cmp++;
    if (actual !== want) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, actual, want);
    end
  endtask

  // One clock with the given inputs; expected register state follows the update priority.
  task automatic cycle(input string name, input logic [31:0] ins, input logic v,
                       input logic st, input logic fl, input logic r);
    ctrl_t      m;
    logic [2:0] imm;
    InstrD = ins; ValidD = v; StallE = st; FlushE = fl; rst = r;
    model(ins, v, m, imm);
    #1;
    check_imm({name, "_imm"}, imm);
    @(posedge clk);
    if (r || fl) exp_e = '0;
    else if (!st) exp_e = m;
    #1;
    check_e(name, exp_e);
    $display("txn %-10s instr=%h v=%b st=%b fl=%b rst=%b -> E=%h", name, ins, v, st, fl, r, got);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [6:0] op, f7;
    int unsigned k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h33};
    k = $urandom_range(0, 11);
    if (k == 11) return $urandom;
    op = (k == 10) ? 7'($urandom) : ops[k];
    case ($urandom_range(0, 3))
      0:       f7 = 7'h20;
      1:       f7 = 7'($urandom);
      default: f7 = 7'h00;
    endcase
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), op};
  endfunction

  vec_t vecs [15];

  initial begin
    vecs[0]  = '{"add",     32'h002081B3, 1'b1, 3'd0, mk(ADD, 0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 1, 2, 3, 0, 1)};
    vecs[1]  = '{"sub",     32'h402081B3, 1'b1, 3'd0, mk(SUB, 0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 1, 2, 3, 0, 1)};
    vecs[2]  = '{"srai",    32'h40335293, 1'b1, 3'd0, mk(SRA, 1, 0, 0, 1, 0, 0, 0, 0, 3'd5, 6, 3, 5, 0, 1)};
    vecs[3]  = '{"srli",    32'h00335293, 1'b1, 3'd0, mk(SRL, 1, 0, 0, 1, 0, 0, 0, 0, 3'd5, 6, 3, 5, 0, 1)};
    vecs[4]  = '{"sll_alt", 32'h402091B3, 1'b1, 3'd0, mk(ADD, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 2, 3, 1, 1)};
    vecs[5]  = '{"bltu",    32'h0020E463, 1'b1, 3'd2, mk(SLTU, 0, 0, 0, 0, 0, 1, 0, 0, 3'd6, 1, 2, 8, 0, 1)};
    vecs[6]  = '{"br_f3_2", 32'h0020A463, 1'b1, 3'd0, mk(ADD, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 2, 8, 1, 1)};
    vecs[7]  = '{"lui",     32'h123450B7, 1'b1, 3'd3, mk(ADD, 1, 2, 0, 1, 0, 0, 0, 0, 3'd5, 8, 3, 1, 0, 1)};
    vecs[8]  = '{"auipc",   32'h00001097, 1'b1, 3'd3, mk(ADD, 1, 1, 0, 1, 0, 0, 0, 0, 3'd1, 0, 0, 1, 0, 1)};
    vecs[9]  = '{"jal",     32'h008000EF, 1'b1, 3'd4, mk(ADD, 0, 0, 2, 1, 0, 0, 1, 0, 3'd0, 0, 8, 1, 0, 1)};
    vecs[10] = '{"lw",      32'h0000A103, 1'b1, 3'd0, mk(ADD, 1, 0, 1, 1, 0, 0, 0, 0, 3'd2, 1, 0, 2, 0, 1)};
    vecs[11] = '{"sw",      32'h0020A223, 1'b1, 3'd1, mk(ADD, 1, 0, 0, 0, 1, 0, 0, 0, 3'd2, 1, 2, 4, 0, 1)};
    vecs[12] = '{"jalr",    32'h000080E7, 1'b1, 3'd0, mk(ADD, 1, 0, 2, 1, 0, 0, 1, 1, 3'd0, 1, 0, 1, 0, 1)};
    vecs[13] = '{"ones_v1", 32'hFFFFFFFF, 1'b1, 3'd0, mk(ADD, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 31, 31, 31, 1, 1)};
    vecs[14] = '{"ones_v0", 32'hFFFFFFFF, 1'b0, 3'd0, '0};

    // Reset holds a real instruction at the inputs; E must stay at zero.
    InstrD = 32'h002081B3; ValidD = 1'b1; StallE = 1'b0; FlushE = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_e("reset", '0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_e("post_reset", vecs[0].exp);
    exp_e = vecs[0].exp;

    for (int i = 0; i < 15; i++) begin
      InstrD = vecs[i].instr; ValidD = vecs[i].valid; StallE = 1'b0; FlushE = 1'b0; rst = 1'b0;
      #1;
      check_imm({vecs[i].name, "_imm"}, vecs[i].imm);
      @(posedge clk);
      #1;
      check_e(vecs[i].name, vecs[i].exp);
      exp_e = vecs[i].exp;
      $display("txn %-10s instr=%h v=%b -> E=%h", vecs[i].name, vecs[i].instr, vecs[i].valid, got);
    end

    // Stall holds add while a store waits in Decode, then the store loads.
    cycle("ld_add", 32'h002081B3, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle("stall", 32'h0020A223, 1'b1, 1'b1, 1'b0, 1'b0);
      check_e("stall_hold_add", vecs[0].exp);
    end
    cycle("release", 32'h0020A223, 1'b1, 1'b0, 1'b0, 1'b0);
    check_bit("release_memwrite", MemWriteE, 1'b1);
    cycle("st_fl", 32'h002081B3, 1'b1, 1'b1, 1'b1, 1'b0);
    check_bit("stall_flush_valid", ValidE, 1'b0);
    cycle("ld_add2", 32'h002081B3, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("invalid", 32'h002081B3, 1'b0, 1'b0, 1'b0, 1'b0);
    check_bit("invalid_regwrite", RegWriteE, 1'b0);
    // Reset during a stall discards the held instruction.
    cycle("ld_lui", 32'h123450B7, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("stall2", 32'h008000EF, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle("rst_stall", 32'h008000EF, 1'b1, 1'b1, 1'b1, 1'b1);
    check_e("rst_mid_stall", '0);
    cycle("stall3", 32'h008000EF, 1'b1, 1'b1, 1'b0, 1'b0);
    check_bit("held_bubble_valid", ValidE, 1'b0);
    cycle("rel2", 32'h008000EF, 1'b1, 1'b0, 1'b0, 1'b0);
    check_bit("rel2_jump", JumpE, 1'b1);

    for (int i = 0; i < 400; i++) begin
      cycle("rand", rand_instr(), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 31) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
